// File: rtl/mips_pkg.sv
// Shared definitions for the single-issue MIPS datapath: fetch FSM states,
// opcode constants used by fetch, the control decoder and the bench.
package mips_pkg;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam int INST_W = 32;

    // Byte addresses of instructions are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle of the fetch stage's memory, decode and redirect signals.
// master = fetch unit, slave = surrounding memory/decode/branch logic.
interface instr_fetch_if #(
    parameter int PC_W = 32
);
    // instruction memory
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;

    // decode side
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst;
    logic [PC_W-1:0] inst_pc;
    logic [5:0]      op;
    logic [5:0]      funct;

    // branch resolution
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output inst_valid, inst, inst_pc, op, funct,
        input  inst_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  inst_valid, inst, inst_pc, op, funct,
        output inst_ready,
        output redirect_valid, redirect_pc
    );

endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, req/ack fetch from instruction memory,
// one held instruction for decode, and taken-branch redirect.
module instr_fetch
    import mips_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master bus
);

    fetch_state_e    state_reg, state_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic [PC_W-1:0] inst_pc_reg, inst_pc_next;
    logic [31:0]     inst_reg, inst_next;
    logic            valid_reg, valid_next;
    logic            capture;
    logic [PC_W-1:0] redirect_target;
    logic [1:0]      unused_redirect_lsbs;

    assign redirect_target      = {bus.redirect_pc[PC_W-1:2], 2'b00};
    assign unused_redirect_lsbs = bus.redirect_pc[1:0];

    // A redirect in the same cycle as an ack discards the returned word.
    assign capture = (state_reg == FETCH) && bus.imem_ack && !bus.redirect_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= FETCH;
            pc_reg      <= RESET_PC;
            inst_reg    <= '0;
            inst_pc_reg <= '0;
            valid_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            inst_reg    <= inst_next;
            inst_pc_reg <= inst_pc_next;
            valid_reg   <= valid_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (bus.redirect_valid) begin
            state_next = FETCH;
        end else begin
            case (state_reg)
                FETCH:   if (bus.imem_ack)   state_next = HOLD;
                HOLD:    if (bus.inst_ready) state_next = FETCH;
                default: state_next = FETCH;
            endcase
        end
    end

    always_comb begin
        pc_next      = pc_reg;
        inst_next    = inst_reg;
        inst_pc_next = inst_pc_reg;
        valid_next   = valid_reg;
        if (bus.redirect_valid) begin
            pc_next    = redirect_target;
            valid_next = 1'b0;
        end else if (capture) begin
            inst_next    = bus.imem_rdata;
            inst_pc_next = pc_reg;
            pc_next      = pc_reg + PC_W'(4);   // wraps modulo 2^PC_W
            valid_next   = 1'b1;
        end else if ((state_reg == HOLD) && bus.inst_ready) begin
            valid_next = 1'b0;
        end
    end

    always_comb begin
        bus.imem_req   = (state_reg == FETCH) && !reset;
        bus.imem_addr  = pc_reg;
        bus.inst_valid = valid_reg;
        bus.inst       = inst_reg;
        bus.inst_pc    = inst_pc_reg;
        bus.op         = inst_reg[31:26];
        bus.funct      = inst_reg[5:0];
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised scoreboard bench for instr_fetch with directed test-plan cases.
module tb_instr_fetch;
    import mips_pkg::*;

    localparam int          PC_W = 32;
    localparam logic [31:0] RST_PC = DEFAULT_RESET_PC;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    instr_fetch_if #(.PC_W(PC_W)) bus ();

    instr_fetch #(.PC_W(PC_W), .RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: test-plan words at 0..C, a hash elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0:   return 32'h0000_0020;
            32'h4:   return 32'h8C01_0004;
            32'h8:   return 32'hAC01_0008;
            32'hC:   return 32'h1000_0003;
            default: return {addr[15:0] ^ 16'h5A3C, addr[31:16] ^ 16'hC3A5};
        endcase
    endfunction

    assign bus.imem_rdata = mem_word(bus.imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic ack, input logic rdy,
                         input logic rv, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        reset              = rst;
        bus.imem_ack       = ack;
        bus.inst_ready     = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
    endtask

    // Reference model: PC plus a "holding an instruction" flag.
    logic [31:0] m_pc = RST_PC;
    logic        m_hold = 1'b0;
    logic        m_rst_prev = 1'b1;

    always @(negedge clk) begin
        chk("model_req", {31'd0, bus.imem_req}, {31'd0, !reset && !m_hold});
        if (!reset && !m_hold) chk("model_addr", bus.imem_addr, m_pc);
        chk("model_valid", {31'd0, bus.inst_valid}, {31'd0, m_hold});
        if (m_rst_prev) begin
            chk("reset_inst", bus.inst, 32'h0);
            chk("reset_inst_pc", bus.inst_pc, 32'h0);
        end
        m_rst_prev = reset;
        if (reset) begin
            m_pc   = RST_PC;
            m_hold = 1'b0;
        end else if (bus.redirect_valid) begin
            m_pc   = bus.redirect_pc & 32'hFFFF_FFFC;
            m_hold = 1'b0;
        end else if (!m_hold && bus.imem_ack) begin
            sb_q.push_back('{word: mem_word(m_pc), pc: m_pc});
            m_pc   = m_pc + 32'd4;
            m_hold = 1'b1;
        end else if (m_hold && bus.inst_ready) begin
            m_hold = 1'b0;
        end
    end

    // Monitor: every newly presented instruction is popped and compared.
    logic        prev_valid = 1'b0;
    logic [31:0] prev_inst = '0;
    logic [31:0] prev_pc = '0;
    exp_t        got;

    always @(negedge clk) begin
        if (bus.inst_valid && !prev_valid) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected", bus.inst_pc, 32'hDEAD_BEEF);
            end else begin
                got = sb_q.pop_front();
                chk("sb_inst", bus.inst, got.word);
                chk("sb_inst_pc", bus.inst_pc, got.pc);
                chk("sb_op", {26'd0, bus.op}, {26'd0, got.word[31:26]});
                chk("sb_funct", {26'd0, bus.funct}, {26'd0, got.word[5:0]});
            end
        end else if (bus.inst_valid && prev_valid) begin
            chk("hold_inst", bus.inst, prev_inst);
            chk("hold_inst_pc", bus.inst_pc, prev_pc);
        end
        prev_valid = bus.inst_valid;
        prev_inst  = bus.inst;
        prev_pc    = bus.inst_pc;
    end

    logic [5:0] ops [4];

    initial begin
        bus.imem_ack       = 1'b0;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        ops[0] = OP_RTYPE; ops[1] = OP_LW; ops[2] = OP_SW; ops[3] = OP_BEQ;

        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_valid", {31'd0, bus.inst_valid}, 32'd0);

        // streaming, zero-wait memory, decode always ready
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 1, 0, 0);
            @(negedge clk);
            chk("stream_valid", {31'd0, bus.inst_valid}, 32'(i % 2));
            if (bus.inst_valid) begin
                chk("stream_op", {26'd0, bus.op}, {26'd0, ops[i/2]});
                chk("stream_pc", bus.inst_pc, 32'(4 * (i / 2)));
            end
        end

        // memory wait states
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, 0);
            @(negedge clk);
            chk("wait_req", {31'd0, bus.imem_req}, 32'd1);
            chk("wait_addr", bus.imem_addr, 32'h10);
        end
        drive(0, 1, 1, 0, 0);
        @(negedge clk);
        chk("wait_ack_valid", {31'd0, bus.inst_valid}, 32'd0);

        // decode backpressure
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0);
            @(negedge clk);
            chk("bp_valid", {31'd0, bus.inst_valid}, 32'd1);
            chk("bp_inst_pc", bus.inst_pc, 32'h10);
            chk("bp_req", {31'd0, bus.imem_req}, 32'd0);
        end
        drive(0, 0, 1, 0, 0);

        // redirect coinciding with ack
        drive(0, 1, 0, 1, 32'h0000_0043);
        @(negedge clk);
        chk("redir_ack_addr_before", bus.imem_addr, 32'h14);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("redir_ack_addr", bus.imem_addr, 32'h40);
        chk("redir_ack_req", {31'd0, bus.imem_req}, 32'd1);
        chk("redir_ack_valid", {31'd0, bus.inst_valid}, 32'd0);

        // redirect during HOLD drops the held instruction
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 32'h0000_0100);
        @(negedge clk);
        chk("redir_hold_valid_before", {31'd0, bus.inst_valid}, 32'd1);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("redir_hold_valid", {31'd0, bus.inst_valid}, 32'd0);
        chk("redir_hold_addr", bus.imem_addr, 32'h100);

        // PC wrap at the top of the address space
        drive(0, 0, 0, 1, 32'hFFFF_FFFC);
        drive(0, 1, 0, 0, 0);
        @(negedge clk);
        chk("wrap_fetch_addr", bus.imem_addr, 32'hFFFF_FFFC);
        drive(0, 0, 1, 0, 0);
        @(negedge clk);
        chk("wrap_inst_pc", bus.inst_pc, 32'hFFFF_FFFC);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("wrap_next_addr", bus.imem_addr, 32'h0);
        chk("wrap_next_req", {31'd0, bus.imem_req}, 32'd1);

        // reset asserted while holding an instruction
        drive(0, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_hold_req", {31'd0, bus.imem_req}, 32'd0);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_hold_valid", {31'd0, bus.inst_valid}, 32'd0);
        chk("rst_hold_addr", bus.imem_addr, RST_PC);

        // randomised traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            drive(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 11) == 0), rpc);
        end

        for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0);
        @(negedge clk);
        chk("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
